// File: rtl/pulse_sched_pkg.sv
// Shared constants, state encoding and sizing helper for the pulse scheduler.
package pulse_sched_pkg;

  localparam int unsigned DefaultNreq = 4;
  localparam int unsigned DefaultW    = 8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StPulse = 2'd1;
  localparam state_t StGap   = 2'd2;

  // Index width for a requester count; never below 1 so ports stay legal.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search: first set req bit at or above ptr, wrapping.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int unsigned NREQ = DefaultNreq
) (
  input  logic [NREQ-1:0]        req,
  input  logic [ptr_w(NREQ)-1:0] ptr,
  output logic                   valid,
  output logic [NREQ-1:0]        grant,
  output logic [ptr_w(NREQ)-1:0] idx
);

  localparam int unsigned PTR_W = ptr_w(NREQ);

  logic [PTR_W:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr + k stays below 2*NREQ, so one conditional subtract is a full modulo.
      cand = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(NREQ)) begin
        cand = cand - (PTR_W + 1)'(NREQ);
      end
      if (!valid && req[cand[PTR_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[PTR_W-1:0];
      end
    end
    grant = valid ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Round-robin sharing of one pulse-width timer among NREQ requesters.
// Optional post-pulse idle gap enabled by defining PULSE_SCHED_GAP_EN.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int unsigned NREQ = DefaultNreq,
  parameter int unsigned W    = DefaultW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*W-1:0]      width,
`ifdef PULSE_SCHED_GAP_EN
  input  logic [W-1:0]           gap,
`endif
  output logic                   pulse_out,
  output logic [NREQ-1:0]        grant,
  output logic [ptr_w(NREQ)-1:0] active_id,
  output logic [NREQ-1:0]        done,
  output logic                   busy
);

  localparam int unsigned PTR_W = ptr_w(NREQ);

  state_t           state_q, state_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0] id_q, id_d;
  logic [NREQ-1:0]  done_q, done_d;

  logic             arb_valid;
  logic [NREQ-1:0]  arb_grant;
  logic [PTR_W-1:0] arb_idx;
  logic [W-1:0]     win_width;
  logic [PTR_W-1:0] next_ptr;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign win_width = width[arb_idx*W +: W];
  assign next_ptr  = (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    id_d    = id_q;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (enable && arb_valid) begin
          ptr_d = next_ptr;
          // A zero-width request completes at once without touching the line.
          if (win_width == '0) begin
            done_d = arb_grant;
          end else begin
            state_d = StPulse;
            cnt_d   = win_width;
            grant_d = arb_grant;
            id_d    = arb_idx;
          end
        end
      end
      StPulse: begin
        if (cnt_q == W'(1)) begin
          done_d  = grant_q;
          grant_d = '0;
          id_d    = '0;
`ifdef PULSE_SCHED_GAP_EN
          if (gap != '0) begin
            state_d = StGap;
            cnt_d   = gap;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef PULSE_SCHED_GAP_EN
      StGap: begin
        if (cnt_q == W'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out = (state_q == StPulse);
  assign busy      = (state_q != StIdle);
  assign grant     = grant_q;
  assign active_id = id_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler (NREQ=4, W=8): vector table, directed
// corner sequences and a randomized run against an interval-based reference model.
module tb_pulse_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req;
  logic [31:0] width;
`ifdef PULSE_SCHED_GAP_EN
  logic [7:0]  gap;
`endif
  logic        pulse_out;
  logic [3:0]  grant;
  logic [1:0]  active_id;
  logic [3:0]  done;
  logic        busy;

  pulse_scheduler #(
    .NREQ (4),
    .W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .width     (width),
`ifdef PULSE_SCHED_GAP_EN
    .gap       (gap),
`endif
    .pulse_out (pulse_out),
    .grant     (grant),
    .active_id (active_id),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    enable = 1'b1;
    width  = '0;
`ifdef PULSE_SCHED_GAP_EN
    gap    = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (interval arithmetic on cycle numbers) -----
  longint m_edge, m_next_arb, m_ps, m_pe, m_gap_end, m_done_cyc;
  int     m_ptr, m_owner, m_done_id;
  logic   e_pulse, e_busy;
  logic [3:0] e_grant, e_done;
  logic [1:0] e_id;

  task automatic model_init();
    m_edge = 0; m_next_arb = 0; m_ps = -1; m_pe = -2; m_gap_end = -2;
    m_done_cyc = -1; m_ptr = 0; m_owner = 0; m_done_id = 0;
  endtask

  // Edge e produces the outputs of cycle e+1 from the inputs present before it.
  task automatic model_edge();
    longint t;
    int     g, win, wd;
    t = m_edge + 1;
    if (m_edge == m_pe) begin
      g = 0;
`ifdef PULSE_SCHED_GAP_EN
      g = int'(gap);
`endif
      m_gap_end  = m_pe + g;
      m_next_arb = m_pe + 1 + g;
    end
    if (m_edge >= m_next_arb && enable && req != 0) begin
      win = -1;
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      end
      m_ptr     = (win + 1) % 4;
      wd        = int'(width[win*8 +: 8]);
      m_done_id = win;
      if (wd == 0) begin
        m_done_cyc = t;
        m_next_arb = m_edge + 1;
      end else begin
        m_owner    = win;
        m_ps       = t;
        m_pe       = t + wd - 1;
        m_gap_end  = m_pe;
        m_done_cyc = m_pe + 1;
        m_next_arb = 64'h7fff_ffff_ffff;
      end
    end
    e_pulse = (t >= m_ps && t <= m_pe);
    e_grant = e_pulse ? 4'(1 << m_owner) : 4'b0;
    e_id    = e_pulse ? 2'(m_owner) : 2'd0;
    e_done  = (t == m_done_cyc) ? 4'(1 << m_done_id) : 4'b0;
    e_busy  = e_pulse || (t > m_pe && t <= m_gap_end);
    m_edge++;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] widths;
    int          id;
    int          len;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [3:0] oh;
    int starts[$];
    int ids[$];
    logic prev;

    vecs[0] = '{req: 4'b0100, widths: {8'd0, 8'd5, 8'd0, 8'd0},   id: 2, len: 5};
    vecs[1] = '{req: 4'b1010, widths: {8'd7, 8'd0, 8'd3, 8'd0},   id: 1, len: 3};
    vecs[2] = '{req: 4'b1000, widths: {8'd1, 8'd0, 8'd0, 8'd0},   id: 3, len: 1};
    vecs[3] = '{req: 4'b1111, widths: {8'd2, 8'd2, 8'd2, 8'd255}, id: 0, len: 255};
    vecs[4] = '{req: 4'b0110, widths: {8'd0, 8'd4, 8'd0, 8'd0},   id: 1, len: 0};

    // Reset state.
    rst_n = 1'b0; req = '0; enable = 1'b0; width = '0;
`ifdef PULSE_SCHED_GAP_EN
    gap = '0;
`endif
    #3;
    check("reset_outputs", {pulse_out, busy, grant, active_id, done}, '0);

    // Single-transaction vectors from reset.
    foreach (vecs[v]) begin
      do_reset();
      req   = vecs[v].req;
      width = vecs[v].widths;
      oh    = 4'(1 << vecs[v].id);
      for (int t = 1; t <= vecs[v].len + 1; t++) begin
        tick();
        if (t <= vecs[v].len) begin
          check($sformatf("vec%0d_pulse", v), {pulse_out, busy, grant, active_id, done},
                {1'b1, 1'b1, oh, 2'(vecs[v].id), 4'b0});
        end else begin
          check($sformatf("vec%0d_done", v), {pulse_out, busy, grant, active_id, done},
                {1'b0, 1'b0, 4'b0, 2'b0, oh});
        end
      end
    end

    // Fairness: continuous requests, width 3 each.
    do_reset();
    req = 4'b1111; width = {8'd3, 8'd3, 8'd3, 8'd3};
    prev = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (pulse_out && !prev) begin
        starts.push_back(t);
        ids.push_back(int'(active_id));
      end
      if (pulse_out && done != 0) check("fair_done_vs_pulse", {pulse_out, done}, {1'b0, done});
      prev = pulse_out;
    end
    check("fair_count", 64'(starts.size()), 64'd5);
    for (int k = 0; k < starts.size() && k < 5; k++) begin
      check($sformatf("fair_start%0d", k), 64'(starts[k]), 64'(1 + 4 * k));
      check($sformatf("fair_id%0d", k), 64'(ids[k]), 64'(k % 4));
    end

    // Zero width then wrap: pointer must sit at 2, so req[3] beats req[0].
    do_reset();
    width = {8'd255, 8'd0, 8'd0, 8'd0};
    req   = 4'b0010;
    tick();
    check("zw_done", {pulse_out, busy, grant, done}, {1'b0, 1'b0, 4'b0, 4'b0010});
    req = 4'b1001;
    tick();
    check("zw_ptr_winner", {pulse_out, grant, active_id}, {1'b1, 4'b1000, 2'd3});
    cnt = 0;
    for (int t = 0; t < 300 && pulse_out; t++) begin
      cnt++;
      tick();
    end
    check("wide_len", 64'(cnt), 64'd255);
    check("wide_done", {pulse_out, done}, {1'b0, 4'b1000});

    // Enable low mid-pulse.
    do_reset();
    width = {8'd0, 8'd0, 8'd6, 8'd2};
    req   = 4'b0010;
    tick();
    check("en_grant", {pulse_out, active_id}, {1'b1, 2'd1});
    tick();
    enable = 1'b0;
    req    = 4'b0011;
    for (int t = 3; t <= 6; t++) begin
      tick();
      check($sformatf("en_hold_c%0d", t), {pulse_out, active_id}, {1'b1, 2'd1});
    end
    tick();
    check("en_done", {pulse_out, done}, {1'b0, 4'b0010});
    req = 4'b0001;
    repeat (4) begin
      tick();
      check("en_blocked", {pulse_out, busy, grant}, {1'b0, 1'b0, 4'b0});
    end
    enable = 1'b1;
    tick();
    check("en_resume", {pulse_out, grant, active_id}, {1'b1, 4'b0001, 2'd0});

    // Reset mid-pulse: in-flight pulse lost, pointer back to 0.
    do_reset();
    width = {8'd0, 8'd2, 8'd0, 8'd10};
    req   = 4'b0101;
    repeat (3) tick();
    check("rst_pre", {pulse_out, active_id}, {1'b1, 2'd0});
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {pulse_out, busy, grant, done}, '0);
    repeat (2) begin
      tick();
      check("rst_no_done", {pulse_out, done}, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_regrant0", {pulse_out, active_id}, {1'b1, 2'd0});
    repeat (9) tick();
    check("rst_c10", pulse_out, 1'b1);
    tick();
    check("rst_done0", {pulse_out, done}, {1'b0, 4'b0001});
    req = 4'b0100;
    tick();
    check("rst_then2", {pulse_out, active_id}, {1'b1, 2'd2});

`ifdef PULSE_SCHED_GAP_EN
    // Gap of 4 between back-to-back pulses.
    do_reset();
    gap   = 8'd4;
    width = {8'd0, 8'd0, 8'd2, 8'd2};
    req   = 4'b0011;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check($sformatf("gap_pulse_c%0d", t), pulse_out,
            (t == 1 || t == 2 || t == 8 || t == 9));
      check($sformatf("gap_done_c%0d", t), done,
            (t == 3) ? 4'b0001 : (t == 10) ? 4'b0010 : 4'b0000);
      if (done[0]) req[0] = 1'b0;
    end
`endif

    // Randomized run against the reference model.
    do_reset();
    model_init();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        if ($urandom_range(0, 5) == 0)
          width[i*8 +: 8] = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      end
      enable = ($urandom_range(0, 7) != 0);
`ifdef PULSE_SCHED_GAP_EN
      gap = 8'($urandom_range(0, 3));
`endif
      // Rarely the owner withdraws mid-pulse; the pulse must still complete.
      if (e_pulse && $urandom_range(0, 15) == 0) req[m_owner] = 1'b0;
      model_edge();
      tick();
      check("rand", {pulse_out, busy, grant, active_id, done},
            {e_pulse, e_busy, e_grant, e_id, e_done});
      req = req & ~e_done;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
